// File: rtl/mseq_pkg.sv
// rtl/mseq_pkg.sv - shared codes and defaults for the microstore next-state sequencer
package mseq_pkg;

    localparam int DEF_STATE_W = 7;

    typedef enum logic [2:0] {
        N_ENC    = 3'b000,
        N_INC    = 3'b001,
        N_LIT    = 3'b010,
        N_BRANCH = 3'b011,
        N_WAIT   = 3'b100,
        N_CALL   = 3'b101,
        N_RET    = 3'b110,
        N_FETCH  = 3'b111
    } nsel_e;

    typedef enum logic [1:0] {
        COND_MOC  = 2'b00,
        COND_CND  = 2'b01,
        COND_ONE  = 2'b10,
        COND_ZERO = 2'b11
    } cond_e;

endpackage

// File: rtl/mseq_status_mux.sv
// rtl/mseq_status_mux.sv - selects and optionally inverts the status bit tested by the microword
module mseq_status_mux
    import mseq_pkg::*;
(
    input  logic [1:0] cond_sel,
    input  logic       inv,
    input  logic       moc,
    input  logic       cond,
    output logic       status
);

    logic raw;

    always_comb begin
        raw = 1'b0;
        case (cond_e'(cond_sel))
            COND_MOC:  raw = moc;
            COND_CND:  raw = cond;
            COND_ONE:  raw = 1'b1;
            COND_ZERO: raw = 1'b0;
            default:   raw = 1'b0;
        endcase
        status = raw ^ inv;
    end

endmodule

// File: rtl/microstore_sequencer.sv
// rtl/microstore_sequencer.sv - control-state register and next-state selection for the microstore
// Optional wait watchdog enabled by defining WATCHDOG_EN.
module microstore_sequencer
    import mseq_pkg::*;
#(
    parameter int STATE_W     = DEF_STATE_W,
    parameter int FETCH_STATE = 0,
    parameter int FAULT_STATE = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [STATE_W-1:0] enc_state,
    input  logic [STATE_W-1:0] cr_field,
    input  logic [2:0]         n_sel,
    input  logic               inv,
    input  logic [1:0]         cond_sel,
    input  logic               moc,
    input  logic               cond,
    output logic [STATE_W-1:0] state,
    output logic               stall,
    output logic               seq_err,
    output logic               wd_fault
);

    localparam logic [STATE_W-1:0] FETCH_C = FETCH_STATE[STATE_W-1:0];

    logic               status;
    logic [STATE_W-1:0] state_inc;
    logic [STATE_W-1:0] ret_reg;
    logic               ret_valid;

    mseq_status_mux u_status (
        .cond_sel (cond_sel),
        .inv      (inv),
        .moc      (moc),
        .cond     (cond),
        .status   (status)
    );

    // Natural STATE_W-bit wrap gives 127+1 -> 0 for both the step and the call push.
    assign state_inc = state + {{(STATE_W-1){1'b0}}, 1'b1};

    always_comb begin
        stall = 1'b0;
        if (!reset && (nsel_e'(n_sel) == N_WAIT))
            stall = !status;
    end

`ifdef WATCHDOG_EN
    localparam logic [STATE_W-1:0] FAULT_C   = FAULT_STATE[STATE_W-1:0];
    localparam logic [7:0]         TIMEOUT_C = TIMEOUT[7:0];

    logic [7:0] wd_cnt;
    logic       wd_trip;

    assign wd_trip = stall && (wd_cnt == TIMEOUT_C);
`else
    logic wd_trip;

    assign wd_trip  = 1'b0;
    assign wd_fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH_C;
            ret_reg   <= '0;
            ret_valid <= 1'b0;
            seq_err   <= 1'b0;
`ifdef WATCHDOG_EN
            wd_fault  <= 1'b0;
            wd_cnt    <= '0;
`endif
        end else if (wd_trip) begin
`ifdef WATCHDOG_EN
            state    <= FAULT_C;
            wd_fault <= 1'b1;
            wd_cnt   <= '0;
`endif
        end else begin
`ifdef WATCHDOG_EN
            wd_cnt <= stall ? wd_cnt + 8'd1 : 8'd0;
`endif
            case (nsel_e'(n_sel))
                N_ENC:    state <= enc_state;
                N_INC:    state <= state_inc;
                N_LIT:    state <= cr_field;
                N_BRANCH: state <= status ? cr_field : state_inc;
                N_WAIT:   state <= status ? state_inc : state;
                N_CALL: begin
                    // A nested call simply replaces the single saved return point.
                    ret_reg   <= state_inc;
                    ret_valid <= 1'b1;
                    state     <= cr_field;
                end
                N_RET: begin
                    ret_valid <= 1'b0;
                    if (ret_valid) begin
                        state <= ret_reg;
                    end else begin
                        state   <= FETCH_C;
                        seq_err <= 1'b1;
                    end
                end
                N_FETCH:  state <= FETCH_C;
                default:  state <= FETCH_C;
            endcase
        end
    end

endmodule

// File: tb/tb_microstore_sequencer.sv
// tb/tb_microstore_sequencer.sv - scoreboard bench for microstore_sequencer
module tb_microstore_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] enc_state;
    logic [6:0] cr_field;
    logic [2:0] n_sel;
    logic       inv;
    logic [1:0] cond_sel;
    logic       moc;
    logic       cond;
    logic [6:0] state;
    logic       stall;
    logic       seq_err;
    logic       wd_fault;

    int errors = 0;
    int checks = 0;
    logic exp_err;
    logic exp_wdf;

    typedef struct {
        logic [6:0] st;
        logic       err;
        logic       wdf;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    microstore_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .enc_state (enc_state),
        .cr_field  (cr_field),
        .n_sel     (n_sel),
        .inv       (inv),
        .cond_sel  (cond_sel),
        .moc       (moc),
        .cond      (cond),
        .state     (state),
        .stall     (stall),
        .seq_err   (seq_err),
        .wd_fault  (wd_fault)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs are set by the caller at the falling edge; stall is checked here, the state after the edge by the monitor.
    task automatic step(input logic [6:0] exp_state, input logic exp_stall);
        exp_t e;
        #1;
        check("stall", {31'd0, stall}, {31'd0, exp_stall});
        e.st  = exp_state;
        e.err = exp_err;
        e.wdf = exp_wdf;
        sb.push_back(e);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("state", {25'd0, state}, {25'd0, e.st});
            check("seq_err", {31'd0, seq_err}, {31'd0, e.err});
            check("wd_fault", {31'd0, wd_fault}, {31'd0, e.wdf});
        end
    end

    task automatic drive(input logic [2:0] ns, input logic [6:0] cr);
        n_sel    = ns;
        cr_field = cr;
    endtask

    initial begin
        reset = 1'b1; enc_state = '0; cr_field = '0; n_sel = 3'b001;
        inv = 1'b0; cond_sel = 2'b00; moc = 1'b0; cond = 1'b0;
        exp_err = 1'b0; exp_wdf = 1'b0;
        @(negedge clk);

        step(7'd0, 1'b0);
        step(7'd0, 1'b0);
        reset = 1'b0;
        step(7'd1, 1'b0);

        enc_state = 7'd7;  drive(3'b000, 7'd0); step(7'd7, 1'b0);
        enc_state = 7'd30;                      step(7'd30, 1'b0);

        drive(3'b100, 7'd0); cond_sel = 2'b00; moc = 1'b0;
        for (int i = 0; i < 3; i++) step(7'd30, 1'b1);
        moc = 1'b1; step(7'd31, 1'b0);
        moc = 1'b0;
        cond_sel = 2'b11; step(7'd31, 1'b1);
        inv = 1'b1;       step(7'd32, 1'b0);
        inv = 1'b0;

        drive(3'b010, 7'd20); step(7'd20, 1'b0);
        drive(3'b101, 7'd50); step(7'd50, 1'b0);
        drive(3'b110, 7'd0);  step(7'd21, 1'b0);
        exp_err = 1'b1;       step(7'd0, 1'b0);

        drive(3'b010, 7'd127); step(7'd127, 1'b0);
        drive(3'b001, 7'd0);   step(7'd0, 1'b0);
        drive(3'b011, 7'd40); cond_sel = 2'b01; cond = 1'b0; inv = 1'b1;
        step(7'd40, 1'b0);
        cond_sel = 2'b10; step(7'd41, 1'b0);
        inv = 1'b0;       step(7'd40, 1'b0);
        drive(3'b111, 7'd9); step(7'd0, 1'b0);

        drive(3'b010, 7'd127); step(7'd127, 1'b0);
        drive(3'b101, 7'd5);   step(7'd5, 1'b0);
        drive(3'b110, 7'd0);   step(7'd0, 1'b0);

        drive(3'b101, 7'd60);  step(7'd60, 1'b0);
        reset = 1'b1; exp_err = 1'b0; step(7'd0, 1'b0);
        reset = 1'b0;
        drive(3'b110, 7'd0); exp_err = 1'b1; step(7'd0, 1'b0);

        drive(3'b100, 7'd0); cond_sel = 2'b00; moc = 1'b0; inv = 1'b0;
`ifdef WATCHDOG_EN
        for (int i = 0; i < 255; i++) step(7'd0, 1'b1);
        exp_wdf = 1'b1; step(7'd2, 1'b1);
        for (int i = 0; i < 10; i++) step(7'd2, 1'b1);
        reset = 1'b1; exp_err = 1'b0; exp_wdf = 1'b0; step(7'd0, 1'b0);
        reset = 1'b0;
`else
        for (int i = 0; i < 300; i++) step(7'd0, 1'b1);
`endif
        moc = 1'b1; step(7'd1, 1'b0);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
